// File: rtl/dx_corr_pkg.sv
// Shared constants and types for the dx correction controller.
package dx_corr_pkg;

    localparam int unsigned AVS_AW = 3;
    localparam int unsigned AVS_DW = 32;

    localparam logic [AVS_AW-1:0] ADDR_SHADOW = 3'd0;
    localparam logic [AVS_AW-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [AVS_AW-1:0] ADDR_STATUS = 3'd2;
    localparam logic [AVS_AW-1:0] ADDR_ACTIVE = 3'd3;
    localparam logic [AVS_AW-1:0] ADDR_FCNT   = 3'd4;

    localparam int unsigned CTRL_COMMIT = 0;
    localparam int unsigned CTRL_AUTO   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_PENDING = 0;
    localparam int unsigned ST_APPLIED = 1;
    localparam int unsigned ST_OVERRUN = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        PUSH       = 2'd2
    } dx_corr_state_e;

endpackage

// File: rtl/dx_corr_regs.sv
// Avalon-MM register file: shadow/control/status registers and registered readback.
module dx_corr_regs
    import dx_corr_pkg::*;
#(
    parameter int unsigned DW     = 10,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AVS_AW-1:0] avs_address,
    input  logic              avs_write,
    input  logic [AVS_DW-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [AVS_DW-1:0] avs_readdata,
    input  logic              set_applied,
    input  logic              set_overrun,
    input  logic              pending,
    input  logic [DW-1:0]     active,
    input  logic [FCNT_W-1:0] frame_cnt,
    output logic [DW-1:0]     shadow,
    output logic              commit_pulse,
    output logic              auto,
    output logic              irq_en,
    output logic              irq
);

    logic [DW-1:0]     shadow_q, shadow_d;
    logic              auto_q, auto_d;
    logic              irq_en_q, irq_en_d;
    logic              applied_q, applied_d;
    logic              overrun_q, overrun_d;
    logic [AVS_DW-1:0] readdata_q, readdata_d;
    logic [AVS_DW-1:0] rdata_c;
    logic              wr_ctrl, wr_status;

    always_comb begin
        wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
        wr_status    = avs_write && (avs_address == ADDR_STATUS);
        commit_pulse = wr_ctrl && avs_writedata[CTRL_COMMIT];

        shadow_d = shadow_q;
        if (avs_write && (avs_address == ADDR_SHADOW)) shadow_d = avs_writedata[DW-1:0];
        auto_d   = wr_ctrl ? avs_writedata[CTRL_AUTO]   : auto_q;
        irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;

        // Hardware set takes priority over a same-cycle write-1-to-clear
        applied_d = set_applied | (applied_q & ~(wr_status & avs_writedata[ST_APPLIED]));
        overrun_d = set_overrun | (overrun_q & ~(wr_status & avs_writedata[ST_OVERRUN]));

        rdata_c = '0;
        case (avs_address)
            ADDR_SHADOW: rdata_c = AVS_DW'(shadow_q);
            ADDR_CTRL:   rdata_c = AVS_DW'({irq_en_q, auto_q, 1'b0});
            ADDR_STATUS: rdata_c = AVS_DW'({overrun_q, applied_q, pending});
            ADDR_ACTIVE: rdata_c = AVS_DW'(active);
            ADDR_FCNT:   rdata_c = AVS_DW'(frame_cnt);
            default:     rdata_c = '0;
        endcase
        readdata_d = avs_read ? rdata_c : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= '0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            applied_q  <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            applied_q  <= applied_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    assign shadow       = shadow_q;
    assign auto         = auto_q;
    assign irq_en       = irq_en_q;
    assign irq          = applied_q & irq_en_q;
    assign avs_readdata = readdata_q;

endmodule

// File: rtl/dx_corr_ctrl.sv
// Stages a host-written dx correction and hands it to the video datapath at a frame boundary.
module dx_corr_ctrl
    import dx_corr_pkg::*;
#(
    parameter int unsigned    DW         = 10,
    parameter int unsigned    FCNT_W     = 16,
    parameter logic [DW-1:0]  ACTIVE_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AVS_AW-1:0] avs_address,
    input  logic              avs_write,
    input  logic [AVS_DW-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [AVS_DW-1:0] avs_readdata,
    input  logic              frame_start,
    input  logic              corr_ready,
    output logic              corr_valid,
    output logic [DW-1:0]     corr_dx,
    output logic              irq
);

    dx_corr_state_e    state_q, state_d;
    logic [DW-1:0]     staged_q, staged_d;
    logic [DW-1:0]     active_q, active_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              corr_valid_q, corr_valid_d;
    logic [DW-1:0]     corr_dx_q, corr_dx_d;
    logic              set_applied, set_overrun;
    logic [DW-1:0]     shadow;
    logic              commit_pulse, auto, irq_en;

    dx_corr_regs #(.DW(DW), .FCNT_W(FCNT_W)) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .set_applied  (set_applied),
        .set_overrun  (set_overrun),
        .pending      (state_q != IDLE),
        .active       (active_q),
        .frame_cnt    (fcnt_q),
        .shadow       (shadow),
        .commit_pulse (commit_pulse),
        .auto         (auto),
        .irq_en       (irq_en),
        .irq          (irq)
    );

    always_comb begin
        state_d     = state_q;
        staged_d    = staged_q;
        active_d    = active_q;
        set_applied = 1'b0;
        set_overrun = 1'b0;
        fcnt_d      = fcnt_q + FCNT_W'(frame_start);

        case (state_q)
            // A commit outranks a same-cycle frame_start and waits for the next frame
            IDLE: begin
                if (commit_pulse) begin
                    staged_d = shadow;
                    state_d  = WAIT_FRAME;
                end else if (frame_start && auto) begin
                    staged_d = shadow;
                    state_d  = PUSH;
                end
            end
            WAIT_FRAME: begin
                if (commit_pulse) staged_d = shadow;
                if (frame_start)  state_d  = PUSH;
            end
            PUSH: begin
                set_overrun = commit_pulse;
                if (corr_ready) begin
                    active_d    = staged_q;
                    set_applied = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        corr_valid_d = (state_d == PUSH);
        corr_dx_d    = (state_d == PUSH) ? staged_d : active_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            staged_q     <= '0;
            active_q     <= ACTIVE_RST;
            fcnt_q       <= '0;
            corr_valid_q <= 1'b0;
            corr_dx_q    <= ACTIVE_RST;
        end else begin
            state_q      <= state_d;
            staged_q     <= staged_d;
            active_q     <= active_d;
            fcnt_q       <= fcnt_d;
            corr_valid_q <= corr_valid_d;
            corr_dx_q    <= corr_dx_d;
        end
    end

    assign corr_valid = corr_valid_q;
    assign corr_dx    = corr_dx_q;

endmodule

// File: tb/tb_dx_corr_ctrl.sv
// Directed bench for dx_corr_ctrl: register access, frame-aligned apply, overrun, auto/irq, reset.
module tb_dx_corr_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        frame_start;
    logic        corr_ready;
    logic        corr_valid;
    logic [9:0]  corr_dx;
    logic        irq;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;
    logic [31:0] rd;

    dx_corr_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .frame_start  (frame_start),
        .corr_ready   (corr_ready),
        .corr_valid   (corr_valid),
        .corr_dx      (corr_dx),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic avs_wr(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address = addr; avs_writedata = data; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        data = avs_readdata;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        corr_ready = 1'b1;
        @(negedge clk);
        corr_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; frame_start = 1'b0; corr_ready = 1'b0;

        // 1. reset
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(corr_valid), 32'h0);
        chk("rst_dx", 32'(corr_dx), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        avs_rd(3'd3, rd); chk("rst_active", rd, 32'h0);
        avs_rd(3'd2, rd); chk("rst_status", rd, 32'h0);

        // 2. basic commit
        avs_wr(3'd0, 32'h1F3);
        avs_rd(3'd0, rd); chk("shadow_rb", rd, 32'h1F3);
        avs_wr(3'd1, 32'h1);
        avs_rd(3'd2, rd); chk("pending", rd, 32'h1);
        chk("no_valid_before_frame", 32'(corr_valid), 32'h0);
        frame_pulse();
        chk("basic_valid", 32'(corr_valid), 32'h1);
        chk("basic_dx", 32'(corr_dx), 32'h1F3);
        repeat (3) @(negedge clk);
        chk("basic_valid_hold", 32'(corr_valid), 32'h1);
        ack();
        chk("basic_valid_drop", 32'(corr_valid), 32'h0);
        chk("basic_dx_hold", 32'(corr_dx), 32'h1F3);
        avs_rd(3'd3, rd); chk("basic_active", rd, 32'h1F3);
        avs_rd(3'd2, rd); chk("basic_status", rd, 32'h2);
        avs_rd(3'd1, rd); chk("ctrl_commit_reads0", rd, 32'h0);
        avs_rd(3'd6, rd); chk("unused_addr", rd, 32'h0);
        avs_wr(3'd2, 32'h2);

        // 3. restage before frame
        avs_wr(3'd0, 32'h010);
        avs_wr(3'd1, 32'h1);
        avs_wr(3'd0, 32'h020);
        avs_wr(3'd1, 32'h1);
        frame_pulse();
        chk("restage_dx", 32'(corr_dx), 32'h020);
        ack();
        avs_rd(3'd3, rd); chk("restage_active", rd, 32'h020);
        avs_rd(3'd2, rd); chk("restage_no_overrun", rd, 32'h2);
        avs_wr(3'd2, 32'h2);

        // 4. overrun during push
        avs_wr(3'd0, 32'h055);
        avs_wr(3'd1, 32'h1);
        frame_pulse();
        avs_wr(3'd0, 32'h066);
        avs_wr(3'd1, 32'h1);
        avs_rd(3'd2, rd); chk("overrun_status", rd, 32'h5);
        chk("overrun_dx_stable", 32'(corr_dx), 32'h055);
        ack();
        avs_rd(3'd3, rd); chk("overrun_active", rd, 32'h055);
        avs_rd(3'd2, rd); chk("overrun_after_ack", rd, 32'h6);
        avs_wr(3'd2, 32'h4);
        avs_rd(3'd2, rd); chk("overrun_w1c", rd, 32'h2);
        avs_wr(3'd2, 32'h2);
        avs_rd(3'd2, rd); chk("applied_w1c", rd, 32'h0);

        // 5. auto + irq, then frame counter wrap
        avs_wr(3'd1, 32'h6);
        avs_wr(3'd0, 32'h3FF);
        chk("irq_idle", 32'(irq), 32'h0);
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            chk($sformatf("auto_valid%0d", i), 32'(corr_valid), 32'h1);
            chk($sformatf("auto_dx%0d", i), 32'(corr_dx), 32'h3FF);
            ack();
        end
        avs_rd(3'd4, rd); chk("fcnt_6", rd, 32'd6);
        chk("irq_set", 32'(irq), 32'h1);
        avs_wr(3'd2, 32'h2);
        chk("irq_clr", 32'(irq), 32'h0);
        avs_wr(3'd1, 32'h0);
        @(negedge clk);
        frame_start = 1'b1;
        repeat (65529) @(negedge clk);
        frame_start = 1'b0;
        avs_rd(3'd4, rd); chk("fcnt_max", rd, 32'hFFFF);
        chk("no_push_auto_off", 32'(corr_valid), 32'h0);
        frame_pulse();
        avs_rd(3'd4, rd); chk("fcnt_wrap", rd, 32'h0);

        // 6a. reset mid-push
        avs_wr(3'd0, 32'h077);
        avs_wr(3'd1, 32'h1);
        frame_pulse();
        chk("pre_rst_valid", 32'(corr_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(corr_valid), 32'h0);
        chk("async_rst_dx", 32'(corr_dx), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        avs_rd(3'd2, rd); chk("post_rst_status", rd, 32'h0);
        avs_rd(3'd3, rd); chk("post_rst_active", rd, 32'h0);
        avs_rd(3'd0, rd); chk("post_rst_shadow", rd, 32'h0);

        // 6b. commit and frame_start in the same cycle
        avs_wr(3'd0, 32'h099);
        @(negedge clk);
        avs_address = 3'd1; avs_writedata = 32'h1; avs_write = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; frame_start = 1'b0;
        chk("same_cycle_no_push", 32'(corr_valid), 32'h0);
        avs_rd(3'd2, rd); chk("same_cycle_pending", rd, 32'h1);
        chk("same_cycle_still_idle_out", 32'(corr_valid), 32'h0);
        frame_pulse();
        chk("same_cycle_next_valid", 32'(corr_valid), 32'h1);
        chk("same_cycle_next_dx", 32'(corr_dx), 32'h099);
        ack();
        avs_rd(3'd3, rd); chk("same_cycle_active", rd, 32'h099);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
